control_sequencer: RTL and testbench

//  Parametrised successor of the multi-cycle control unit. Sequences FETCH..WRITE_REG with valid/done

---
 rtl/cu_pkg.sv | 47 ++++
 rtl/cu_watchdog.sv | 28 ++
 rtl/control_sequencer.sv | 262 ++++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
// The sequencer top and its watchdog both import this package.
package cu_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    READ_REG,
    EXECUTE,
    MEM_READ,
    MEM_WRITE,
    WRITE_REG,
    RETIRE,
    HALT,
    TRAP
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_TIMEOUT = 2'b01,
    CAUSE_ILLEGAL = 2'b10
  } trap_cause_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] TYPE_R = 3'b000;
  localparam logic [2:0] TYPE_I = 3'b001;
  localparam logic [2:0] TYPE_S = 3'b010;
  localparam logic [2:0] TYPE_B = 3'b011;
  localparam logic [2:0] TYPE_J = 3'b100;

  // Branches with funct3 010/011 have no defined compare, so they are illegal.
  function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_JAL: return 1'b1;
      OP_BRANCH: return (f3 != 3'b010) && (f3 != 3'b011);
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cu_watchdog.sv
// Per-state wait watchdog: counts consecutive cycles without a done and
// flags expiry on the last allowed cycle so the FSM can divert to TRAP.
module cu_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cycles;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cycles <= '0;
    else if (clear)
      cycles <= '0;
    else if (count)
      cycles <= cycles + CW'(1);
  end

  assign expire = count && (cycles == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: walks FETCH..WRITE_REG with valid/done
// handshakes, owns the PC, resolves branches/JAL and traps on faults.
module control_sequencer
  import cu_pkg::*;
#(
  parameter int              XLEN           = 32,
  parameter int              TIMEOUT_CYCLES = 64,
  parameter logic [XLEN-1:0] RESET_PC       = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            halt_req,
  output logic            fetch_enable,
  output logic [XLEN-1:0] fetch_pc,
  input  logic            fetch_done,
  input  logic [31:0]     instruction,
  output logic            decode_enable,
  output logic [31:0]     instruction_to_decode,
  input  logic            decode_done,
  input  logic [6:0]      opcode,
  input  logic [4:0]      rd,
  input  logic [2:0]      funct3,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] imm,
  input  logic [2:0]      instr_type,
  output logic            reg_read_enable,
  output logic [4:0]      reg_rs1,
  output logic [4:0]      reg_rs2,
  input  logic [XLEN-1:0] reg_read_data1,
  input  logic [XLEN-1:0] reg_read_data2,
  input  logic            reg_read_data_valid,
  output logic            reg_write_enable,
  output logic [4:0]      reg_rd,
  output logic [XLEN-1:0] reg_write_data,
  input  logic            reg_write_done,
  output logic            alu_enable,
  output logic [XLEN-1:0] alu_operand1,
  output logic [XLEN-1:0] alu_operand2,
  input  logic            alu_done,
  input  logic [XLEN-1:0] alu_result,
  output logic            memory_read_enable,
  output logic            memory_write_enable,
  output logic [XLEN-1:0] memory_address,
  output logic [XLEN-1:0] memory_write_data,
  input  logic [XLEN-1:0] memory_read_data,
  input  logic            memory_read_data_valid,
  input  logic            memory_write_done,
  output logic            trap,
  output logic [1:0]      trap_cause,
  output logic            halted,
  output logic [31:0]     retired_count
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_t          state, state_next;
  trap_cause_t     cause_q;
  logic [XLEN-1:0] pc, rs1_data, rs2_data, imm_q, alu_q, mem_q;
  logic [31:0]     instr_q, retired;
  logic [6:0]      opcode_q;
  logic [4:0]      rd_q, rs1_q, rs2_q;
  logic [2:0]      funct3_q, type_q;
  logic            waiting, done_now, wd_expire, taken;

  // funct7 only selects ALU variants, which the external ALU decodes itself.
  logic unused_funct7;
  assign unused_funct7 = ^funct7;

  always_comb begin
    waiting  = 1'b1;
    done_now = 1'b0;
    case (state)
      FETCH:     done_now = fetch_done;
      DECODE:    done_now = decode_done;
      READ_REG:  done_now = reg_read_data_valid;
      EXECUTE:   done_now = alu_done;
      MEM_READ:  done_now = memory_read_data_valid;
      MEM_WRITE: done_now = memory_write_done;
      WRITE_REG: begin
        waiting  = (rd_q != 5'd0);
        done_now = reg_write_done;
      end
      default:   waiting = 1'b0;
    endcase
  end

  cu_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_next != state),
    .count  (waiting && !done_now),
    .expire (wd_expire)
  );

  always_comb begin
    case (funct3_q)
      3'b000:  taken = (rs1_data == rs2_data);
      3'b001:  taken = (rs1_data != rs2_data);
      3'b100:  taken = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  taken = (rs1_data <  rs2_data);
      3'b111:  taken = (rs1_data >= rs2_data);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      state_next = FETCH;
      FETCH:     if (fetch_done) state_next = DECODE;
      DECODE:    if (decode_done) state_next = is_legal(opcode, funct3) ? READ_REG : TRAP;
      READ_REG:  if (reg_read_data_valid) state_next = EXECUTE;
      EXECUTE:
        if (alu_done) begin
          case (opcode_q)
            OP_LOAD:   state_next = MEM_READ;
            OP_STORE:  state_next = MEM_WRITE;
            OP_BRANCH: state_next = RETIRE;
            default:   state_next = WRITE_REG;
          endcase
        end
      MEM_READ:  if (memory_read_data_valid) state_next = WRITE_REG;
      MEM_WRITE: if (memory_write_done) state_next = RETIRE;
      WRITE_REG: if (rd_q == 5'd0 || reg_write_done) state_next = RETIRE;
      RETIRE:    state_next = halt_req ? HALT : FETCH;
      HALT:      if (!halt_req) state_next = FETCH;
      TRAP:      state_next = TRAP;
      default:   state_next = IDLE;
    endcase
    if (wd_expire) state_next = TRAP;
  end

  // Operand/result registers only load on their stage's handshake, so PC and
  // the retire counter stay frozen in HALT and TRAP without extra gating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cause_q  <= CAUSE_NONE;
      pc       <= RESET_PC;
      retired  <= '0;
      instr_q  <= '0;
      opcode_q <= '0;
      rd_q     <= '0;
      funct3_q <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      type_q   <= '0;
      imm_q    <= '0;
      rs1_data <= '0;
      rs2_data <= '0;
      alu_q    <= '0;
      mem_q    <= '0;
    end else begin
      state <= state_next;
      if (state_next == TRAP && state != TRAP)
        cause_q <= wd_expire ? CAUSE_TIMEOUT : CAUSE_ILLEGAL;
      case (state)
        FETCH: if (fetch_done) instr_q <= instruction;
        DECODE:
          if (decode_done) begin
            opcode_q <= opcode;
            rd_q     <= rd;
            funct3_q <= funct3;
            rs1_q    <= rs1;
            rs2_q    <= rs2;
            type_q   <= instr_type;
            imm_q    <= imm;
          end
        READ_REG:
          if (reg_read_data_valid) begin
            rs1_data <= reg_read_data1;
            rs2_data <= reg_read_data2;
          end
        EXECUTE:  if (alu_done) alu_q <= alu_result;
        MEM_READ: if (memory_read_data_valid) mem_q <= memory_read_data;
        RETIRE: begin
          retired <= retired + 32'd1;
          pc      <= (opcode_q == OP_JAL || (opcode_q == OP_BRANCH && taken)) ? alu_q : pc + PC_STEP;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    fetch_enable          = 1'b0;
    fetch_pc              = '0;
    decode_enable         = 1'b0;
    instruction_to_decode = '0;
    reg_read_enable       = 1'b0;
    reg_rs1               = '0;
    reg_rs2               = '0;
    reg_write_enable      = 1'b0;
    reg_rd                = '0;
    reg_write_data        = '0;
    alu_enable            = 1'b0;
    alu_operand1          = '0;
    alu_operand2          = '0;
    memory_read_enable    = 1'b0;
    memory_write_enable   = 1'b0;
    memory_address        = '0;
    memory_write_data     = '0;
    case (state)
      FETCH: begin
        fetch_enable = 1'b1;
        fetch_pc     = pc;
      end
      DECODE: begin
        decode_enable         = 1'b1;
        instruction_to_decode = instr_q;
      end
      READ_REG: begin
        reg_read_enable = 1'b1;
        reg_rs1         = rs1_q;
        reg_rs2         = rs2_q;
      end
      EXECUTE: begin
        alu_enable = 1'b1;
        case (type_q)
          TYPE_I, TYPE_S: begin
            alu_operand1 = rs1_data;
            alu_operand2 = imm_q;
          end
          TYPE_B, TYPE_J: begin
            alu_operand1 = pc;
            alu_operand2 = imm_q;
          end
          default: begin
            alu_operand1 = rs1_data;
            alu_operand2 = rs2_data;
          end
        endcase
      end
      MEM_READ: begin
        memory_read_enable = 1'b1;
        memory_address     = alu_q;
      end
      MEM_WRITE: begin
        memory_write_enable = 1'b1;
        memory_address      = alu_q;
        memory_write_data   = rs2_data;
      end
      WRITE_REG:
        if (rd_q != 5'd0) begin
          reg_write_enable = 1'b1;
          reg_rd           = rd_q;
          reg_write_data   = (opcode_q == OP_LOAD) ? mem_q :
                             (opcode_q == OP_JAL)  ? pc + PC_STEP : alu_q;
        end
      default: ;
    endcase
  end

  assign trap          = (state == TRAP);
  assign trap_cause    = cause_q;
  assign halted        = (state == HALT);
  assign retired_count = retired;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: plays every handshake partner and
// compares observed outputs against hand-computed values.
module tb_control_sequencer;

  localparam logic [6:0] R_OP  = 7'b0110011;
  localparam logic [6:0] I_OP  = 7'b0010011;
  localparam logic [6:0] LD_OP = 7'b0000011;
  localparam logic [6:0] ST_OP = 7'b0100011;
  localparam logic [6:0] BR_OP = 7'b1100011;
  localparam logic [6:0] J_OP  = 7'b1101111;

  logic        clk = 1'b0;
  logic        reset, halt_req;
  logic        fetch_enable, fetch_done, decode_enable, decode_done;
  logic [31:0] fetch_pc, instruction, instruction_to_decode, imm;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2, reg_rs1, reg_rs2, reg_rd;
  logic [2:0]  funct3, instr_type;
  logic        reg_read_enable, reg_read_data_valid, reg_write_enable, reg_write_done;
  logic [31:0] reg_read_data1, reg_read_data2, reg_write_data;
  logic        alu_enable, alu_done;
  logic [31:0] alu_operand1, alu_operand2, alu_result;
  logic        memory_read_enable, memory_write_enable, memory_read_data_valid, memory_write_done;
  logic [31:0] memory_address, memory_write_data, memory_read_data;
  logic        trap, halted;
  logic [1:0]  trap_cause;
  logic [31:0] retired_count;

  int          total = 0;
  int          bad = 0;
  logic        wr_seen;
  logic [31:0] obs_fetch_pc, obs_rs1, obs_rs2, obs_op1, obs_op2, obs_addr, obs_wdata, obs_rd, obs_rdata;

  control_sequencer #(.XLEN(32), .TIMEOUT_CYCLES(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .halt_req(halt_req),
    .fetch_enable(fetch_enable), .fetch_pc(fetch_pc), .fetch_done(fetch_done), .instruction(instruction),
    .decode_enable(decode_enable), .instruction_to_decode(instruction_to_decode), .decode_done(decode_done),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7), .imm(imm),
    .instr_type(instr_type),
    .reg_read_enable(reg_read_enable), .reg_rs1(reg_rs1), .reg_rs2(reg_rs2),
    .reg_read_data1(reg_read_data1), .reg_read_data2(reg_read_data2), .reg_read_data_valid(reg_read_data_valid),
    .reg_write_enable(reg_write_enable), .reg_rd(reg_rd), .reg_write_data(reg_write_data),
    .reg_write_done(reg_write_done),
    .alu_enable(alu_enable), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_done(alu_done), .alu_result(alu_result),
    .memory_read_enable(memory_read_enable), .memory_write_enable(memory_write_enable),
    .memory_address(memory_address), .memory_write_data(memory_write_data),
    .memory_read_data(memory_read_data), .memory_read_data_valid(memory_read_data_valid),
    .memory_write_done(memory_write_done),
    .trap(trap), .trap_cause(trap_cause), .halted(halted), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  // Remembers any register-file write strobe so x0 and store/branch skips can be checked.
  always @(negedge clk) if (reg_write_enable) wr_seen = 1'b1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic stageEnable(input int which);
    case (which)
      0:       return fetch_enable;
      1:       return decode_enable;
      2:       return reg_read_enable;
      3:       return alu_enable;
      4:       return memory_read_enable;
      5:       return memory_write_enable;
      default: return reg_write_enable;
    endcase
  endfunction

  task automatic waitStage(input int which, input string tag);
    for (int i = 0; i < 20 && !stageEnable(which); i++) @(negedge clk);
    checkOutput({tag, "_en"}, 32'(stageEnable(which)), 32'd1);
  endtask

  task automatic pulseDone(input int which, input int delay);
    repeat (delay) @(negedge clk);
    case (which)
      0:       fetch_done = 1'b1;
      1:       decode_done = 1'b1;
      2:       reg_read_data_valid = 1'b1;
      3:       alu_done = 1'b1;
      4:       memory_read_data_valid = 1'b1;
      5:       memory_write_done = 1'b1;
      default: reg_write_done = 1'b1;
    endcase
    @(negedge clk);
    fetch_done = 1'b0; decode_done = 1'b0; reg_read_data_valid = 1'b0; alu_done = 1'b0;
    memory_read_data_valid = 1'b0; memory_write_done = 1'b0; reg_write_done = 1'b0;
  endtask

  task automatic applyStimulus(input string tag, input logic [6:0] op, input logic [4:0] rd_i,
                               input logic [2:0] f3, input logic [4:0] rs1_i, input logic [4:0] rs2_i,
                               input logic [31:0] imm_i, input logic [2:0] ty, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] res, input logic [31:0] mdata);
    logic [31:0] word;
    word = {7'b0, rs2_i, rs1_i, f3, rd_i, op};
    wr_seen = 1'b0;
    waitStage(0, {tag, "_fetch"});
    obs_fetch_pc = fetch_pc;
    instruction = word;
    pulseDone(0, 1);
    waitStage(1, {tag, "_decode"});
    checkOutput({tag, "_ir"}, instruction_to_decode, word);
    opcode = op; rd = rd_i; funct3 = f3; rs1 = rs1_i; rs2 = rs2_i; imm = imm_i; instr_type = ty;
    pulseDone(1, 1);
    waitStage(2, {tag, "_read"});
    obs_rs1 = 32'(reg_rs1); obs_rs2 = 32'(reg_rs2);
    reg_read_data1 = d1; reg_read_data2 = d2;
    pulseDone(2, 1);
    waitStage(3, {tag, "_exec"});
    obs_op1 = alu_operand1; obs_op2 = alu_operand2;
    alu_result = res;
    pulseDone(3, 1);
    if (op == LD_OP) begin
      waitStage(4, {tag, "_mrd"});
      obs_addr = memory_address;
      memory_read_data = mdata;
      pulseDone(4, 1);
    end
    if (op == ST_OP) begin
      waitStage(5, {tag, "_mwr"});
      obs_addr = memory_address; obs_wdata = memory_write_data;
      pulseDone(5, 1);
    end
    if (op != ST_OP && op != BR_OP && rd_i != 5'd0) begin
      waitStage(6, {tag, "_wb"});
      obs_rd = 32'(reg_rd); obs_rdata = reg_write_data;
      pulseDone(6, 1);
    end
  endtask

  task automatic nextFetch(input string tag, input logic [31:0] want_pc, input logic [31:0] want_cnt);
    waitStage(0, {tag, "_next"});
    checkOutput({tag, "_next_pc"}, fetch_pc, want_pc);
    checkOutput({tag, "_count"}, retired_count, want_cnt);
  endtask

  initial begin
    reset = 1'b1; halt_req = 1'b0;
    fetch_done = 1'b0; decode_done = 1'b0; reg_read_data_valid = 1'b0; alu_done = 1'b0;
    memory_read_data_valid = 1'b0; memory_write_done = 1'b0; reg_write_done = 1'b0;
    instruction = '0; opcode = '0; rd = '0; funct3 = '0; rs1 = '0; rs2 = '0; funct7 = '0;
    imm = '0; instr_type = '0; reg_read_data1 = '0; reg_read_data2 = '0; alu_result = '0;
    memory_read_data = '0; wr_seen = 1'b0;
    obs_fetch_pc = '0; obs_rs1 = '0; obs_rs2 = '0; obs_op1 = '0; obs_op2 = '0;
    obs_addr = '0; obs_wdata = '0; obs_rd = '0; obs_rdata = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_fetch_en", 32'(fetch_enable), 32'd0);
    checkOutput("rst_fetch_pc", fetch_pc, 32'd0);
    checkOutput("rst_trap", {29'b0, trap, trap_cause}, 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    checkOutput("rst_count", retired_count, 32'd0);
    checkOutput("rst_wr_en", 32'(reg_write_enable), 32'd0);
    reset = 1'b0;

    applyStimulus("add", R_OP, 5'd3, 3'b000, 5'd1, 5'd2, 32'd0, 3'b000, 32'd5, 32'd7, 32'd12, 32'd0);
    checkOutput("add_pc", obs_fetch_pc, 32'h0);
    checkOutput("add_srcs", {obs_rs1[15:0], obs_rs2[15:0]}, {16'd1, 16'd2});
    checkOutput("add_op1", obs_op1, 32'd5);
    checkOutput("add_op2", obs_op2, 32'd7);
    checkOutput("add_rd", obs_rd, 32'd3);
    checkOutput("add_wdata", obs_rdata, 32'd12);
    nextFetch("add", 32'h4, 32'd1);

    applyStimulus("sw", ST_OP, 5'd0, 3'b010, 5'd2, 5'd6, 32'h10, 3'b010, 32'h30, 32'hDEADBEEF, 32'h40, 32'd0);
    checkOutput("sw_op2", obs_op2, 32'h10);
    checkOutput("sw_addr", obs_addr, 32'h40);
    checkOutput("sw_data", obs_wdata, 32'hDEADBEEF);
    checkOutput("sw_nowrite", 32'(wr_seen), 32'd0);
    nextFetch("sw", 32'h8, 32'd2);

    applyStimulus("lw", LD_OP, 5'd5, 3'b010, 5'd2, 5'd0, 32'h10, 3'b001, 32'h30, 32'd0, 32'h40, 32'hDEADBEEF);
    checkOutput("lw_addr", obs_addr, 32'h40);
    checkOutput("lw_rd", obs_rd, 32'd5);
    checkOutput("lw_wdata", obs_rdata, 32'hDEADBEEF);
    nextFetch("lw", 32'hC, 32'd3);

    applyStimulus("jal0", J_OP, 5'd0, 3'b000, 5'd0, 5'd0, 32'hF4, 3'b100, 32'd0, 32'd0, 32'h100, 32'd0);
    checkOutput("jal0_op1", obs_op1, 32'hC);
    checkOutput("jal0_nowrite", 32'(wr_seen), 32'd0);
    nextFetch("jal0", 32'h100, 32'd4);

    applyStimulus("jal1", J_OP, 5'd1, 3'b000, 5'd0, 5'd0, 32'd16, 3'b100, 32'd0, 32'd0, 32'h110, 32'd0);
    checkOutput("jal1_op1", obs_op1, 32'h100);
    checkOutput("jal1_op2", obs_op2, 32'd16);
    checkOutput("jal1_rd", obs_rd, 32'd1);
    checkOutput("jal1_wdata", obs_rdata, 32'h104);
    nextFetch("jal1", 32'h110, 32'd5);

    applyStimulus("jmp20", J_OP, 5'd0, 3'b000, 5'd0, 5'd0, 32'hFFFFFF10, 3'b100, 32'd0, 32'd0, 32'h20, 32'd0);
    nextFetch("jmp20", 32'h20, 32'd6);

    applyStimulus("bne", BR_OP, 5'd0, 3'b001, 5'd1, 5'd2, 32'hFFFFFFF8, 3'b011, 32'd9, 32'd9, 32'h18, 32'd0);
    nextFetch("bne", 32'h24, 32'd7);

    applyStimulus("back20", J_OP, 5'd0, 3'b000, 5'd0, 5'd0, 32'hFFFFFFFC, 3'b100, 32'd0, 32'd0, 32'h20, 32'd0);
    nextFetch("back20", 32'h20, 32'd8);

    applyStimulus("beq", BR_OP, 5'd0, 3'b000, 5'd1, 5'd2, 32'hFFFFFFF8, 3'b011, 32'd9, 32'd9, 32'h18, 32'd0);
    checkOutput("beq_op1", obs_op1, 32'h20);
    checkOutput("beq_op2", obs_op2, 32'hFFFFFFF8);
    checkOutput("beq_nowrite", 32'(wr_seen), 32'd0);
    nextFetch("beq", 32'h18, 32'd9);

    applyStimulus("addi_x0", I_OP, 5'd0, 3'b000, 5'd1, 5'd0, 32'd3, 3'b001, 32'd4, 32'd0, 32'd7, 32'd0);
    checkOutput("addi_x0_nowrite", 32'(wr_seen), 32'd0);
    nextFetch("addi_x0", 32'h1C, 32'd10);

    applyStimulus("blt", BR_OP, 5'd0, 3'b100, 5'd1, 5'd2, 32'd8, 3'b011, 32'hFFFFFFFF, 32'd1, 32'h24, 32'd0);
    nextFetch("blt", 32'h24, 32'd11);

    applyStimulus("bltu", BR_OP, 5'd0, 3'b110, 5'd1, 5'd2, 32'd8, 3'b011, 32'hFFFFFFFF, 32'd1, 32'h2C, 32'd0);
    nextFetch("bltu", 32'h28, 32'd12);

    halt_req = 1'b1;
    applyStimulus("add_h", R_OP, 5'd4, 3'b000, 5'd1, 5'd2, 32'd0, 3'b000, 32'd1, 32'd2, 32'd3, 32'd0);
    for (int i = 0; i < 10 && !halted; i++) @(negedge clk);
    checkOutput("halted", 32'(halted), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("halt_hold", {30'b0, halted, fetch_enable}, 32'b10);
    checkOutput("halt_count", retired_count, 32'd13);
    halt_req = 1'b0;
    waitStage(0, "resume");
    checkOutput("resume_pc", fetch_pc, 32'h2C);
    checkOutput("resume_halted", 32'(halted), 32'd0);

    instruction = 32'h0000007F;
    pulseDone(0, 1);
    waitStage(1, "illegal");
    opcode = 7'h7F;
    pulseDone(1, 1);
    checkOutput("illegal_trap", 32'(trap), 32'd1);
    checkOutput("illegal_cause", 32'(trap_cause), 32'b10);
    repeat (3) @(negedge clk);
    checkOutput("illegal_enables", {28'b0, fetch_enable, decode_enable, reg_read_enable, alu_enable}, 32'd0);
    checkOutput("illegal_frozen", retired_count, 32'd13);
    checkOutput("illegal_still", 32'(trap), 32'd1);

    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst2_trap", {29'b0, trap, trap_cause}, 32'd0);
    checkOutput("rst2_count", retired_count, 32'd0);
    reset = 1'b0;
    waitStage(0, "wd_fetch");
    checkOutput("wd_fetch_pc", fetch_pc, 32'h0);
    instruction = 32'h002081B3;
    pulseDone(0, 3);
    waitStage(1, "wd_lastcycle");
    checkOutput("wd_lastcycle_trap", 32'(trap), 32'd0);
    opcode = R_OP; rd = 5'd3; funct3 = 3'b000; rs1 = 5'd1; rs2 = 5'd2; instr_type = 3'b000;
    pulseDone(1, 1);
    waitStage(2, "wd_read");
    pulseDone(2, 1);
    waitStage(3, "wd_exec");
    repeat (3) @(negedge clk);
    checkOutput("wd_exec4", {30'b0, alu_enable, trap}, 32'b10);
    @(negedge clk);
    checkOutput("wd_trap", 32'(trap), 32'd1);
    checkOutput("wd_cause", 32'(trap_cause), 32'b01);
    checkOutput("wd_alu_en", 32'(alu_enable), 32'd0);

    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    waitStage(0, "async");
    #2 reset = 1'b1;
    #1 checkOutput("async_drop", {31'b0, fetch_enable}, 32'd0);
    checkOutput("async_pc", fetch_pc, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
